// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: starts a game on a button pulse, paces snake steps
// from video frame ticks, hands the body shift to the datapath, then evaluates
// collision/fruit and tracks direction, length and score.
//
// Ports:
//   clock_25           system clock, all logic on rising edge
//   reset              synchronous active-low reset
//   frame_tik          one-cycle pulse per video frame
//   right_pulse        one-cycle turn-right request (also starts a game)
//   left_pulse         one-cycle turn-left request (also starts a game)
//   move_done          datapath finished the body shift (MOVE only)
//   collision_detected head hit wall or body (CHECK only)
//   fruit_eaten        head on fruit (CHECK only)
//   game_tik           one-cycle step marker, driven in the WAIT cycle whose
//                      frame_tik completes the step count
//   move_req           one-cycle shift order, first cycle of MOVE
//   grow               qualifies move_req: tail kept
//   direction          00 right, 01 down, 10 left, 11 up
//   snake_length       current length
//   score              fruits eaten (saturating)
//   game_enable        high in WAIT, MOVE, CHECK
//   semaforo           high in MOVE: snake memory owned by the datapath
//   current_state      IDLE=0, WAIT=1, MOVE=2, CHECK=3, GAME_OVER=4
module snake_game_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 6,
  parameter int unsigned START_LENGTH    = 3,
  parameter int unsigned MAX_LENGTH      = 15
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       frame_tik,
  input  logic       right_pulse,
  input  logic       left_pulse,
  input  logic       move_done,
  input  logic       collision_detected,
  input  logic       fruit_eaten,
  output logic       game_tik,
  output logic       move_req,
  output logic       grow,
  output logic [1:0] direction,
  output logic [3:0] snake_length,
  output logic [7:0] score,
  output logic       game_enable,
  output logic       semaforo,
  output logic [2:0] current_state
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SCORE_W = 8;

  localparam logic [CNT_W-1:0]   FPS_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEN_W-1:0]   START_LEN = LEN_W'(START_LENGTH);
  localparam logic [LEN_W-1:0]   MAX_LEN   = LEN_W'(MAX_LENGTH);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_MOVE  = 3'd2,
    S_CHECK = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          dir_q, dir_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                grow_pend_q, grow_pend_d;
  logic                turn_v_q, turn_v_d;     // a turn is pending
  logic                turn_r_q, turn_r_d;     // pending turn is right (else left)
  logic                move_req_q, move_req_d;
  logic                grow_q, grow_d;
  logic                sema_q, sema_d;
  logic                en_q, en_d;
  logic                step_c;
  logic                any_btn_c;
  logic                one_btn_c;

  assign any_btn_c = right_pulse | left_pulse;
  assign one_btn_c = right_pulse ^ left_pulse;

  // State and datapath registers
  always_ff @(posedge clock_25) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_q       <= 2'd0;
      len_q       <= START_LEN;
      score_q     <= '0;
      grow_pend_q <= 1'b0;
      turn_v_q    <= 1'b0;
      turn_r_q    <= 1'b0;
      move_req_q  <= 1'b0;
      grow_q      <= 1'b0;
      sema_q      <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
      score_q     <= score_d;
      grow_pend_q <= grow_pend_d;
      turn_v_q    <= turn_v_d;
      turn_r_q    <= turn_r_d;
      move_req_q  <= move_req_d;
      grow_q      <= grow_d;
      sema_q      <= sema_d;
      en_q        <= en_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    len_d       = len_q;
    score_d     = score_q;
    grow_pend_d = grow_pend_q;
    turn_v_d    = turn_v_q;
    turn_r_d    = turn_r_q;
    move_req_d  = 1'b0;
    grow_d      = 1'b0;
    step_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The starting pulse only launches the game; it is not a turn.
        if (any_btn_c) begin
          state_d     = S_WAIT;
          cnt_d       = '0;
          dir_d       = 2'd0;
          len_d       = START_LEN;
          score_d     = '0;
          grow_pend_d = 1'b0;
          turn_v_d    = 1'b0;
        end
      end

      S_WAIT: begin
        if (frame_tik) begin
          if (cnt_q == FPS_LAST) begin
            step_c      = 1'b1;
            state_d     = S_MOVE;
            cnt_d       = '0;
            move_req_d  = 1'b1;
            grow_d      = grow_pend_q;
            grow_pend_d = 1'b0;
            turn_v_d    = 1'b0;
            if (turn_v_q) begin
              dir_d = turn_r_q ? dir_q + 2'd1 : dir_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_MOVE: begin
        if (move_done) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (collision_detected) begin
          state_d = S_OVER;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
          if (fruit_eaten) begin
            if (score_q != SCORE_MAX) begin
              score_d = score_q + SCORE_W'(1);
            end
            if (len_q < MAX_LEN) begin
              len_d       = len_q + LEN_W'(1);
              grow_pend_d = 1'b1;
            end
          end
        end
      end

      S_OVER: begin
        if (any_btn_c) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Turn capture; a pulse coinciding with the step lands in the next step
    // because the applied turn is cleared above before this re-arms it.
    if ((state_q == S_WAIT || state_q == S_MOVE || state_q == S_CHECK) &&
        one_btn_c && (!turn_v_q || step_c)) begin
      turn_v_d = 1'b1;
      turn_r_d = right_pulse;
    end

    sema_d = (state_d == S_MOVE);
    en_d   = (state_d == S_WAIT) || (state_d == S_MOVE) || (state_d == S_CHECK);
  end

  assign game_tik      = step_c;
  assign move_req      = move_req_q;
  assign grow          = grow_q;
  assign direction     = dir_q;
  assign snake_length  = len_q;
  assign score         = score_q;
  assign game_enable   = en_q;
  assign semaforo      = sema_q;
  assign current_state = state_q;

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 6: frame_tik pulses per snake step (legal 1..63).
REQ-002 Parameter START_LENGTH, default 3: snake length loaded at game start.
REQ-003 Parameter MAX_LENGTH, default 15: snake length saturation value (fits 4 bits).
REQ-004 clock_25  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low; sampled on clock_25 rising edge.
REQ-006 frame_tik  in  1  one-cycle pulse per video frame.
REQ-007 right_pulse  in  1  one-cycle, already-synchronized turn-right request.
REQ-008 left_pulse  in  1  one-cycle, already-synchronized turn-left request.
REQ-009 move_done  in  1  datapath has finished the body shift; valid only in MOVE.
REQ-010 collision_detected  in  1  head hit wall or body; sampled only in CHECK.
REQ-011 fruit_eaten  in  1  head on fruit; sampled only in CHECK.
REQ-012 game_tik  out  1  one-cycle pulse marking each snake step.
REQ-013 move_req  out  1  one-cycle pulse ordering the datapath to shift the snake.
REQ-014 grow  out  1  qualifies move_req; 1 = tail is kept (snake grows).
REQ-015 direction  out  2  00 right, 01 down, 10 left, 11 up.
REQ-016 snake_length  out  4  current length.
REQ-017 score  out  8  fruits eaten.
REQ-018 game_enable  out  1  high in WAIT, MOVE, CHECK.
REQ-019 semaforo  out  1  high in MOVE: snake memory owned by the datapath; renderer must not read.
REQ-020 current_state  out  3  IDLE=0, WAIT=1, MOVE=2, CHECK=3, GAME_OVER=4.

Function
REQ-021 The FSM SHALL leave IDLE on any right_pulse or left_pulse: go to WAIT; direction=00, snake_length=START_LENGTH, score=0, frame counter=0, no pending turn. The starting pulse is not a turn.
REQ-022 WAIT SHALL count frame_tik pulses; on the pulse that makes the count equal FRAMES_PER_STEP: assert game_tik for that one cycle, apply the pending turn to direction, clear the counter, go to MOVE.
REQ-023 frame_tik SHALL be ignored outside WAIT; the counter SHALL be cleared on every entry to WAIT.
REQ-024 move_req SHALL pulse for exactly the first cycle in MOVE; on that cycle grow SHALL equal grow_pending, and grow_pending SHALL clear.
REQ-025 MOVE SHALL hold until move_done=1, then go to CHECK the next cycle. move_done in the move_req cycle is accepted.
REQ-026 CHECK SHALL last one cycle; collision_detected=1 -> GAME_OVER, ignoring fruit_eaten.
REQ-027 CHECK with fruit_eaten=1 and no collision SHALL do the following, then go to WAIT:
- score+1, saturating at 255;
- snake_length+1, saturating at MAX_LENGTH;
- set grow_pending only if length was below MAX_LENGTH.
REQ-028 CHECK with neither input high SHALL go to WAIT with no counter changes.
REQ-029 Turn capture in WAIT, MOVE and CHECK:
- right turn = direction+1 mod 4; left turn = direction-1 mod 4.
- At most one pending turn per step; the first accepted pulse wins and later pulses are ignored until it is applied (prevents 180° reversal in one step).
- right_pulse and left_pulse in the same cycle are both ignored.
REQ-030 A turn pulse arriving in the same cycle as game_tik SHALL be captured for the next step, not the current one.
REQ-031 GAME_OVER SHALL hold score, snake_length and direction, with game_enable=0. Any button pulse -> IDLE; a second pulse is needed to restart.

Reset
REQ-032 With reset=0 at a rising edge, the block SHALL go to IDLE and set:
- game_tik, move_req, grow, semaforo, game_enable = 0;
- direction=00, snake_length=START_LENGTH, score=0;
- counter=0, grow_pending=0, no pending turn.
REQ-033 Reset SHALL take priority over all inputs in every state, including mid-MOVE; move_req SHALL never be issued in the reset cycle.

Verification
REQ-034 Reset then right_pulse -> current_state 0->1, direction=00, length=3, score=0; after 6 frame_tik pulses, exactly one game_tik, then move_req on the next cycle with grow=0 and semaforo=1.
REQ-035 In WAIT, right_pulse followed by left_pulse -> at the next game_tik direction=01; the left_pulse is discarded and direction stays 01 for the following step.
REQ-036 move_done=1, then fruit_eaten=1 in CHECK -> score=1, length=4; the next move_req has grow=1 and the one after has grow=0.
REQ-037 collision_detected=1 and fruit_eaten=1 in CHECK -> GAME_OVER, score unchanged, game_enable=0; first pulse -> IDLE; second pulse -> WAIT with score=0.
REQ-038 Preload length=15 and score=255, then fruit_eaten -> both unchanged and grow=0 on the next move; reset=0 asserted while in MOVE -> IDLE next edge with semaforo=0.
